// File: rtl/cs_resolve_adder_pkg.sv
// cs_resolve_adder_pkg: shared defaults, derived widths and FSM state codes for the carry-save resolver
package cs_resolve_adder_pkg;
   localparam int SIZE_DEF   = 3072;
   localparam int RADIX_DEF  = 78;
   localparam int CHUNK_DEF  = 394;
   localparam int WIDTH_DEF  = SIZE_DEF + RADIX_DEF + 2;
   localparam int NCHUNK_DEF = WIDTH_DEF / CHUNK_DEF;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADD  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/cs_resolve_adder_if.sv
// cs_resolve_adder_if: operand strobe and result bus; CS_RESOLVE_LOW_DIGIT_EN adds the early low-digit outputs
interface cs_resolve_adder_if #(
   parameter int SIZE  = cs_resolve_adder_pkg::SIZE_DEF,
   parameter int RADIX = cs_resolve_adder_pkg::RADIX_DEF
);
   localparam int W = SIZE + RADIX + 2;
   logic           en_in;
   logic [W-1:0]   r0;
   logic [W-1:0]   r1;
   logic [W:0]     sum;
   logic           busy;
   logic           done;
   logic           overrun;
`ifdef CS_RESOLVE_LOW_DIGIT_EN
   logic [RADIX-1:0] q_digit;
   logic             q_valid;
   modport master (output en_in, r0, r1, input sum, busy, done, overrun, q_digit, q_valid);
   modport slave  (input en_in, r0, r1, output sum, busy, done, overrun, q_digit, q_valid);
`else
   modport master (output en_in, r0, r1, input sum, busy, done, overrun);
   modport slave  (input en_in, r0, r1, output sum, busy, done, overrun);
`endif
endinterface

// File: rtl/chunk_adder.sv
// chunk_adder: one CHUNK-wide slice of the resolve, a + b + cin with carry-out
module chunk_adder import cs_resolve_adder_pkg::*; #(
   parameter int CHUNK = CHUNK_DEF
) (
   input  logic [CHUNK-1:0] i_a,
   input  logic [CHUNK-1:0] i_b,
   input  logic             i_cin,
   output logic [CHUNK-1:0] o_s,
   output logic             o_cout
);
   assign {o_cout, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
endmodule

// File: rtl/cs_resolve_adder.sv
// cs_resolve_adder: resolves carry-save r0/r1 into a binary sum one CHUNK per cycle; CS_RESOLVE_LOW_DIGIT_EN exposes the low digit early
module cs_resolve_adder import cs_resolve_adder_pkg::*; #(
   parameter int SIZE  = SIZE_DEF,
   parameter int RADIX = RADIX_DEF,
   parameter int CHUNK = CHUNK_DEF
) (
   input logic               clk,
   input logic               rst,
   cs_resolve_adder_if.slave bus
);
   localparam int W      = SIZE + RADIX + 2;
   localparam int NCHUNK = W / CHUNK;
   localparam int IW     = idx_bits(NCHUNK);
   localparam int BW     = $clog2(W + 1);
   logic [1:0]       r_state;
   logic [W-1:0]     r_r0;
   logic [W-1:0]     r_r1;
   logic [W:0]       r_sum;
   logic [IW-1:0]    r_idx;
   logic             r_carry;
   logic             r_ovr;
   logic             w_add;
   logic             w_start;
   logic             w_last;
   logic             w_cout;
   logic [CHUNK-1:0] w_chunk;
   logic [BW-1:0]    w_base;
   assign w_add   = r_state == S_ADD;
   assign w_start = bus.en_in && !w_add;
   assign w_last  = r_idx == IW'(NCHUNK - 1);
   assign w_base  = BW'(r_idx) * BW'(CHUNK);
   chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
      .i_a    (r_r0[w_base +: CHUNK]),
      .i_b    (r_r1[w_base +: CHUNK]),
      .i_cin  (r_carry),
      .o_s    (w_chunk),
      .o_cout (w_cout)
   );
   // capture operands on an accepted strobe, then walk the chunks low to high rippling the carry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_r0    <= '0;
         r_r1    <= '0;
         r_sum   <= '0;
         r_idx   <= '0;
         r_carry <= 1'b0;
      end else if (w_start) begin
         r_state <= S_ADD;
         r_r0    <= bus.r0;
         r_r1    <= bus.r1;
         r_idx   <= '0;
         r_carry <= 1'b0;
      end else if (w_add) begin
         r_sum[w_base +: CHUNK] <= w_chunk;
         r_carry <= w_cout;
         r_idx   <= r_idx + 1'b1;
         if (w_last) begin
            r_sum[W] <= w_cout;
            r_state  <= S_DONE;
         end
      end else begin
         r_state <= S_IDLE;
      end
   end
   // a strobe arriving mid-resolve is dropped and remembered until reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_ovr <= 1'b0;
      else if (bus.en_in && w_add) r_ovr <= 1'b1;
   end
   assign bus.sum     = r_sum;
   assign bus.busy    = w_add;
   assign bus.done    = r_state == S_DONE;
   assign bus.overrun = r_ovr;
`ifdef CS_RESOLVE_LOW_DIGIT_EN
   logic r_qv;
   // the low digit lives entirely in chunk 0, so it is final right after the first add
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_qv <= 1'b0;
      else r_qv <= w_add && r_idx == '0;
   end
   assign bus.q_valid = r_qv;
   assign bus.q_digit = r_sum[RADIX-1:0];
`endif
endmodule

// File: tb/tb_cs_resolve_adder.sv
// tb_cs_resolve_adder: random and directed stimulus checked every cycle against a chunk-progress model of the resolver
module tb_cs_resolve_adder;
   import cs_resolve_adder_pkg::*;
   localparam int SIZE  = SIZE_DEF;
   localparam int RADIX = RADIX_DEF;
   localparam int CHUNK = CHUNK_DEF;
   localparam int W     = SIZE + RADIX + 2;
   localparam int N     = W / CHUNK;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_err    = 0;
   bit   cmp_en   = 1'b0;
   cs_resolve_adder_if #(.SIZE(SIZE), .RADIX(RADIX)) bus();
   cs_resolve_adder #(.SIZE(SIZE), .RADIX(RADIX), .CHUNK(CHUNK)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   always #5 clk = ~clk;
   // model: age counts cycles since the accepted strobe; after age-1 chunk edges the low (age-1)*CHUNK bits are new
   logic [W:0] m_old = '0;
   logic [W:0] m_new = '0;
   logic [W:0] m_sum = '0;
   int         m_age = -1;
   bit         m_ovr = 1'b0;
   function automatic logic [W:0] mix(input int k);
      logic [W:0] mask;
      mask = (k >= N) ? '1 : (((W+1)'(1) << (k * CHUNK)) - 1'b1);
      return (m_new & mask) | (m_old & ~mask);
   endfunction
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_old = '0;
         m_new = '0;
         m_age = -1;
         m_ovr = 1'b0;
      end else begin
         if (bus.en_in && m_age >= 1 && m_age <= N) m_ovr = 1'b1;
         if (bus.en_in && !(m_age >= 1 && m_age <= N)) begin
            m_old = m_sum;
            m_new = {1'b0, bus.r0} + {1'b0, bus.r1};
            m_age = 1;
         end else if (m_age >= 0) begin
            m_age++;
            if (m_age > N + 1) begin
               m_old = m_new;
               m_age = -1;
            end
         end
      end
      m_sum = (m_age >= 1) ? mix(m_age - 1) : m_old;
   end
   task automatic chk(input string nm, input logic [W:0] got, input logic [W:0] exp);
      int fd;
      fd = -1;
      n_checks++;
      if (got !== exp) begin
         for (int i = W; i >= 0; i--) if (got[i] !== exp[i]) fd = i;
         n_err++;
         $display("FAIL %s at %0t: actual[63:0]=%h required[63:0]=%h actual_msb=%b required_msb=%b lowest_diff_bit=%0d",
                  nm, $time, got[63:0], exp[63:0], got[W], exp[W], fd);
      end
   endtask
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("busy", bus.busy, m_age >= 1 && m_age <= N);
         chk("done", bus.done, m_age == N + 1);
         chk("overrun", bus.overrun, m_ovr);
         chk("sum", bus.sum, m_sum);
`ifdef CS_RESOLVE_LOW_DIGIT_EN
         chk("q_valid", bus.q_valid, m_age == 2);
         chk("q_digit", bus.q_digit, m_sum[RADIX-1:0]);
`endif
      end
   end
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #3;
      end
   endtask
   task automatic strobe(input logic [W-1:0] a, input logic [W-1:0] b);
      bus.en_in = 1'b1;
      bus.r0    = a;
      bus.r1    = b;
      tick();
      bus.en_in = 1'b0;
   endtask
   task automatic rnd(output logic [W-1:0] v, input int mode);
      for (int i = 0; i < W; i++) v[i] = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
   endtask
   logic [W-1:0] a, b;
   logic [W:0]   e;
   logic [7:0]   pat;
   initial begin
      bus.en_in = 1'b0;
      bus.r0    = '0;
      bus.r1    = '0;
      tick(2);
      chk("reset_sum", bus.sum, '0);
      chk("reset_busy", bus.busy, 1'b0);
      chk("reset_done", bus.done, 1'b0);
      chk("reset_overrun", bus.overrun, 1'b0);
      rst    = 1'b0;
      cmp_en = 1'b1;
      tick();
      a = '0;
      a[0] = 1'b1;
      b = '1;
      e = '0;
      e[W] = 1'b1;
      strobe(a, b);
      chk("ones_busy_first", bus.busy, 1'b1);
      tick(7);
      chk("ones_busy_last", bus.busy, 1'b1);
      chk("ones_done_early", bus.done, 1'b0);
      tick();
      chk("ones_done", bus.done, 1'b1);
      chk("ones_busy_off", bus.busy, 1'b0);
      chk("ones_sum_msb_only", bus.sum, e);
      tick();
      chk("ones_done_one_cycle", bus.done, 1'b0);
      chk("ones_sum_hold", bus.sum, e);
      pat = 8'h5A;
      for (int i = 0; i < W; i++) a[i] = pat[i % 8];
      strobe(a, a);
      tick(8);
      chk("b2b_done1", bus.done, 1'b1);
      chk("b2b_sum1", bus.sum, {a, 1'b0});
      strobe(a, a);
      tick(8);
      chk("b2b_done2", bus.done, 1'b1);
      chk("b2b_sum2", bus.sum, {a, 1'b0});
      chk("b2b_overrun", bus.overrun, 1'b0);
      rnd(a, 0);
      rnd(b, 0);
      strobe(a, b);
      tick(3);
      bus.en_in = 1'b1;
      bus.r0    = ~a;
      tick();
      bus.en_in = 1'b0;
      chk("ovr_set", bus.overrun, 1'b1);
      tick(4);
      chk("ovr_done", bus.done, 1'b1);
      chk("ovr_sum", bus.sum, {1'b0, a} + {1'b0, b});
      tick(3);
      chk("ovr_sticky", bus.overrun, 1'b1);
      rnd(a, 0);
      rnd(b, 0);
      strobe(a, b);
      tick(4);
      rst = 1'b1;
      #1;
      chk("rst_sum", bus.sum, '0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_overrun", bus.overrun, 1'b0);
      tick();
      rst = 1'b0;
      tick(12);
      strobe(b, a);
      tick(8);
      chk("post_rst_done", bus.done, 1'b1);
      chk("post_rst_sum", bus.sum, {1'b0, a} + {1'b0, b});
`ifdef CS_RESOLVE_LOW_DIGIT_EN
      a = '0;
      a[RADIX-1:0] = '1;
      b = '0;
      b[0] = 1'b1;
      strobe(a, b);
      tick();
      chk("lowdig_q_valid", bus.q_valid, 1'b1);
      chk("lowdig_q_digit", bus.q_digit, '0);
      tick(7);
      chk("lowdig_done", bus.done, 1'b1);
      chk("lowdig_bit78", bus.sum[RADIX], 1'b1);
`endif
      for (int it = 0; it < 40; it++) begin
         rnd(a, ($urandom_range(0, 5) == 0) ? 1 : ($urandom_range(0, 7) == 0) ? 2 : 0);
         rnd(b, ($urandom_range(0, 5) == 0) ? 1 : 0);
         strobe(a, b);
         for (int g = $urandom_range(6, 12); g > 0; g--) begin
            bus.en_in = ($urandom_range(0, 5) == 0);
            bus.r0    = ~bus.r0;
            bus.r1    = {bus.r1[W-2:0], bus.r1[W-1]};
            tick();
         end
         bus.en_in = 1'b0;
      end
      tick(12);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end
endmodule
